// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the memory request arbiter slice.
//   MEM_* op codes and lengths as seen by the load/store unit and the
//   memory controller, arbiter FSM state codes and owner encoding.
package mem_defs;

   localparam logic [1:0] MEM_NOP  = 2'd0;
   localparam logic [1:0] MEM_LOAD = 2'd1;
   localparam logic [1:0] MEM_SAVE = 2'd2;

   localparam logic [1:0] MEM_BYTE = 2'd0;
   localparam logic [1:0] MEM_HALF = 2'd1;
   localparam logic [1:0] MEM_WORD = 2'd2;

   localparam logic SRC_IF  = 1'b0;
   localparam logic SRC_MEM = 1'b1;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_RESP  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Bundle of every handshake/bus signal around the arbiter.
//   Pipeline side : take_jmp, IF_req/IF_addr/IF_rdy/IF_out,
//                   MEM_op/MEM_len/MEM_addr/MEM_data/MEM_rdy/MEM_out
//   Controller side: ctl_valid/ctl_op/ctl_len/ctl_addr/ctl_data,
//                   ctl_ack/ctl_done/ctl_rdata
// slave  : the arbiter's view.
// master : the surrounding pipeline + memory controller view.
interface mem_req_arbiter_if;

   logic        take_jmp;
   logic        IF_req;
   logic [31:0] IF_addr;
   logic        IF_rdy;
   logic [31:0] IF_out;
   logic [1:0]  MEM_op;
   logic [1:0]  MEM_len;
   logic [31:0] MEM_addr;
   logic [31:0] MEM_data;
   logic        MEM_rdy;
   logic [31:0] MEM_out;
   logic        ctl_valid;
   logic [1:0]  ctl_op;
   logic [1:0]  ctl_len;
   logic [31:0] ctl_addr;
   logic [31:0] ctl_data;
   logic        ctl_ack;
   logic        ctl_done;
   logic [31:0] ctl_rdata;

   modport slave (
      input  take_jmp, IF_req, IF_addr, MEM_op, MEM_len, MEM_addr, MEM_data,
             ctl_ack, ctl_done, ctl_rdata,
      output IF_rdy, IF_out, MEM_rdy, MEM_out,
             ctl_valid, ctl_op, ctl_len, ctl_addr, ctl_data
   );

   modport master (
      output take_jmp, IF_req, IF_addr, MEM_op, MEM_len, MEM_addr, MEM_data,
             ctl_ack, ctl_done, ctl_rdata,
      input  IF_rdy, IF_out, MEM_rdy, MEM_out,
             ctl_valid, ctl_op, ctl_len, ctl_addr, ctl_data
   );

endinterface

// File: rtl/mem_req_arbiter_pick.sv
// mem_arb_pick: combinational winner select for the arbiter's IDLE state.
//   if_req     in  IF has a live fetch request (already masked by flush)
//   mem_req    in  load/store unit has a non-NOP op
//   starve_cnt in  consecutive MEM wins while IF waited (MEM_ARB_STARVE_EN only)
//   grant      out someone is to be issued
//   grant_src  out winner, SRC_IF or SRC_MEM
// Build option MEM_ARB_STARVE_EN: IF wins once starve_cnt reaches
// STARVE_LIMIT; otherwise MEM always has priority.
module mem_arb_pick
   import mem_defs::*;
`ifdef MEM_ARB_STARVE_EN
#(
   parameter int STARVE_LIMIT = 4
)
`endif
(
   input  logic       if_req,
   input  logic       mem_req,
`ifdef MEM_ARB_STARVE_EN
   input  logic [3:0] starve_cnt,
`endif
   output logic       grant,
   output logic       grant_src
);

   always_comb begin
      grant     = if_req | mem_req;
      grant_src = SRC_MEM;
      if (!mem_req) begin
         grant_src = SRC_IF;
      end
`ifdef MEM_ARB_STARVE_EN
      else if (if_req && (starve_cnt == 4'(STARVE_LIMIT))) begin
         grant_src = SRC_IF;
      end
`endif
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares the byte-serial memory controller between
// instruction fetch (IF) and the load/store unit (MEM). One outstanding
// request; IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   clk_in  in  system clock
//   rst_in  in  asynchronous active-high reset (also resets the controller)
//   rdy_in  in  global ready; low freezes every register
//   bus     slave modport of mem_req_arbiter_if (pipeline + controller)
// Build option MEM_ARB_STARVE_EN enables the IF starvation counter;
// without it MEM has strict priority and STARVE_LIMIT only gets range-checked.
module mem_req_arbiter
   import mem_defs::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   mem_req_arbiter_if.slave bus
);

   if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
      $error("mem_req_arbiter: STARVE_LIMIT must be 1..15");
   end

   arb_state_t  state_q, state_d;
   logic        src_q, src_d;
   logic        drop_q, drop_d;
   logic        skip_q, skip_d;
   logic        ctl_valid_q, ctl_valid_d;
   logic [1:0]  ctl_op_q, ctl_op_d;
   logic [1:0]  ctl_len_q, ctl_len_d;
   logic [31:0] ctl_addr_q, ctl_addr_d;
   logic [31:0] ctl_data_q, ctl_data_d;
   logic        if_rdy_q, if_rdy_d;
   logic [31:0] if_out_q, if_out_d;
   logic        mem_rdy_q, mem_rdy_d;
   logic [31:0] mem_out_q, mem_out_d;
   logic        done_now;
   logic        if_live, mem_live;
   logic        grant, grant_src;
`ifdef MEM_ARB_STARVE_EN
   logic [3:0]  starve_q, starve_d;
`endif

   // A flushed fetch is treated as if IF had never asked.
   assign if_live  = bus.IF_req & ~bus.take_jmp;
   assign mem_live = (bus.MEM_op != MEM_NOP);

`ifdef MEM_ARB_STARVE_EN
   mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
      .if_req     (if_live),
      .mem_req    (mem_live),
      .starve_cnt (starve_q),
      .grant      (grant),
      .grant_src  (grant_src)
   );
`else
   mem_arb_pick u_pick (
      .if_req    (if_live),
      .mem_req   (mem_live),
      .grant     (grant),
      .grant_src (grant_src)
   );
`endif

   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      drop_d      = drop_q;
      skip_d      = skip_q;
      ctl_valid_d = ctl_valid_q;
      ctl_op_d    = ctl_op_q;
      ctl_len_d   = ctl_len_q;
      ctl_addr_d  = ctl_addr_q;
      ctl_data_d  = ctl_data_q;
      if_rdy_d    = 1'b0;
      if_out_d    = if_out_q;
      mem_rdy_d   = 1'b0;
      mem_out_d   = mem_out_q;
      done_now    = 1'b0;
`ifdef MEM_ARB_STARVE_EN
      starve_d    = starve_q;
`endif

      case (state_q)
         ARB_IDLE: begin
            drop_d = 1'b0;
            skip_d = 1'b0;
            // skip_q marks the cycle right after a MEM completion: the LSU may
            // still be holding the op it just got MEM_rdy for, so nobody is
            // granted this cycle (IF must not slip in on that gap either).
            if (grant && !skip_q) begin
               state_d     = ARB_ISSUE;
               src_d       = grant_src;
               ctl_valid_d = 1'b1;
               if (grant_src == SRC_IF) begin
                  ctl_op_d   = MEM_LOAD;
                  ctl_len_d  = MEM_WORD;
                  ctl_addr_d = bus.IF_addr;
                  ctl_data_d = '0;
`ifdef MEM_ARB_STARVE_EN
                  starve_d   = '0;
`endif
               end else begin
                  ctl_op_d   = bus.MEM_op;
                  ctl_len_d  = bus.MEM_len;
                  ctl_addr_d = bus.MEM_addr;
                  ctl_data_d = bus.MEM_data;
`ifdef MEM_ARB_STARVE_EN
                  if (if_live && (starve_q != 4'(STARVE_LIMIT))) begin
                     starve_d = starve_q + 4'd1;
                  end
`endif
               end
            end
         end
         ARB_ISSUE: begin
            if ((src_q == SRC_IF) && bus.take_jmp && !bus.ctl_ack) begin
               // Fetch cancelled before the controller took it.
               ctl_valid_d = 1'b0;
               state_d     = ARB_IDLE;
            end else if (bus.ctl_ack) begin
               ctl_valid_d = 1'b0;
               state_d     = ARB_WAIT;
               done_now    = bus.ctl_done;
            end
         end
         ARB_WAIT: begin
            done_now = bus.ctl_done;
         end
         ARB_RESP: begin
            state_d = ARB_IDLE;
            skip_d  = (src_q == SRC_MEM);
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase

      // An accepted fetch cannot be recalled; only its result is discarded.
      if ((src_q == SRC_IF) && bus.take_jmp &&
          ((state_q == ARB_WAIT) || (state_q == ARB_RESP) ||
           ((state_q == ARB_ISSUE) && bus.ctl_ack))) begin
         drop_d = 1'b1;
      end

      if (done_now) begin
         state_d = ARB_RESP;
         if (src_q == SRC_MEM) begin
            mem_rdy_d = 1'b1;
            mem_out_d = bus.ctl_rdata;
         end else if (!drop_d) begin
            if_rdy_d = 1'b1;
            if_out_d = bus.ctl_rdata;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= ARB_IDLE;
         src_q       <= SRC_IF;
         drop_q      <= 1'b0;
         skip_q      <= 1'b0;
         ctl_valid_q <= 1'b0;
         ctl_op_q    <= '0;
         ctl_len_q   <= '0;
         ctl_addr_q  <= '0;
         ctl_data_q  <= '0;
         if_rdy_q    <= 1'b0;
         if_out_q    <= '0;
         mem_rdy_q   <= 1'b0;
         mem_out_q   <= '0;
`ifdef MEM_ARB_STARVE_EN
         starve_q    <= '0;
`endif
      end else if (rdy_in) begin
         state_q     <= state_d;
         src_q       <= src_d;
         drop_q      <= drop_d;
         skip_q      <= skip_d;
         ctl_valid_q <= ctl_valid_d;
         ctl_op_q    <= ctl_op_d;
         ctl_len_q   <= ctl_len_d;
         ctl_addr_q  <= ctl_addr_d;
         ctl_data_q  <= ctl_data_d;
         if_rdy_q    <= if_rdy_d;
         if_out_q    <= if_out_d;
         mem_rdy_q   <= mem_rdy_d;
         mem_out_q   <= mem_out_d;
`ifdef MEM_ARB_STARVE_EN
         starve_q    <= starve_d;
`endif
      end
   end

   assign bus.ctl_valid = ctl_valid_q;
   assign bus.ctl_op    = ctl_op_q;
   assign bus.ctl_len   = ctl_len_q;
   assign bus.ctl_addr  = ctl_addr_q;
   assign bus.ctl_data  = ctl_data_q;
   assign bus.IF_rdy    = if_rdy_q;
   assign bus.IF_out    = if_out_q;
   assign bus.MEM_rdy   = mem_rdy_q;
   assign bus.MEM_out   = mem_out_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a small memory-controller model.
// Expectations for the starvation scenario follow MEM_ARB_STARVE_EN.
module tb_mem_req_arbiter;
   import mem_defs::*;

   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   logic rdy_in = 1'b1;

   mem_req_arbiter_if bus ();

   mem_req_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .rdy_in (rdy_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   int n_chk = 0;
   int n_err = 0;

   // controller model state and observation counters
   int          ack_dly = 0;
   int          done_dly = 1;
   int          c_st = 0;
   int          c_cnt = 0;
   int          n_ack = 0;
   int          n_grant = 0;
   int          n_if_rdy = 0;
   int          n_mem_rdy = 0;
   bit          g_is_if [0:63];
   logic [1:0]  rec_op, rec_len;
   logic [31:0] rec_addr, rec_data;
   logic        prev_if = 1'b0;
   logic        prev_mem = 1'b0;
   logic        d_prev;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rd_f(input logic [31:0] a);
      return (a == 32'h100) ? 32'h00A00093 : (a ^ 32'hA5A50000);
   endfunction

   // Controller model + monitor, evaluated on the falling edge.
   always @(negedge clk_in) begin
      if (rst_in) begin
         c_st = 0;
         c_cnt = 0;
         bus.ctl_ack = 1'b0;
         bus.ctl_done = 1'b0;
         prev_if = 1'b0;
         prev_mem = 1'b0;
      end else begin
         d_prev = bus.ctl_done;
         if (bus.IF_rdy && !prev_if) begin
            n_if_rdy++;
            check("if_rdy_latency", d_prev, 1);
         end
         if (bus.MEM_rdy && !prev_mem) begin
            n_mem_rdy++;
            check("mem_rdy_latency", d_prev, 1);
         end
         prev_if = bus.IF_rdy;
         prev_mem = bus.MEM_rdy;
         bus.ctl_ack = 1'b0;
         bus.ctl_done = 1'b0;
         if (c_st == 0) begin
            if (bus.ctl_valid) begin
               if (c_cnt >= ack_dly) begin
                  bus.ctl_ack = 1'b1;
                  n_ack++;
                  rec_op = bus.ctl_op;
                  rec_len = bus.ctl_len;
                  rec_addr = bus.ctl_addr;
                  rec_data = bus.ctl_data;
                  if (n_grant < 64) g_is_if[n_grant] = (bus.ctl_addr[15:8] < 8'h20);
                  n_grant++;
                  c_cnt = 0;
                  if (done_dly == 0) begin
                     bus.ctl_done = 1'b1;
                     bus.ctl_rdata = rd_f(bus.ctl_addr);
                  end else begin
                     c_st = 2;
                  end
               end else begin
                  c_cnt++;
               end
            end else begin
               c_cnt = 0;
            end
         end else begin
            c_cnt++;
            if (c_cnt >= done_dly) begin
               bus.ctl_done = 1'b1;
               bus.ctl_rdata = rd_f(rec_addr);
               c_st = 0;
               c_cnt = 0;
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk_in);
      #1;
   endtask

   task automatic wait_for(input int which, input string tag);
      bit seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         tick();
         case (which)
            0:       seen = bus.IF_rdy;
            1:       seen = bus.MEM_rdy;
            default: seen = bus.ctl_valid;
         endcase
      end
      check(tag, 32'(seen), 1);
   endtask

   task automatic wait_ack(input int base, input string tag);
      bit seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         tick();
         seen = (n_ack > base);
      end
      check(tag, 32'(seen), 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int b_ack, b_if, b_mem, b_g;
      bus.take_jmp = 1'b0;
      bus.IF_req = 1'b0;
      bus.IF_addr = '0;
      bus.MEM_op = MEM_NOP;
      bus.MEM_len = MEM_WORD;
      bus.MEM_addr = '0;
      bus.MEM_data = '0;
      bus.ctl_ack = 1'b0;
      bus.ctl_done = 1'b0;
      bus.ctl_rdata = '0;

      // reset state
      repeat (3) tick();
      check("rst_ctl_valid", bus.ctl_valid, 0);
      check("rst_if_rdy", bus.IF_rdy, 0);
      check("rst_mem_rdy", bus.MEM_rdy, 0);
      check("rst_ctl_addr", bus.ctl_addr, 0);
      check("rst_ctl_op", bus.ctl_op, 0);
      rst_in = 1'b0;
      tick();
      check("idle_no_valid", bus.ctl_valid, 0);

      // IF fetch alone
      ack_dly = 1; done_dly = 2;
      bus.IF_addr = 32'h100; bus.IF_req = 1'b1;
      tick();
      check("t1_valid_n1", bus.ctl_valid, 1);
      check("t1_op", bus.ctl_op, MEM_LOAD);
      check("t1_len", bus.ctl_len, MEM_WORD);
      check("t1_addr", bus.ctl_addr, 32'h100);
      wait_for(0, "t1_if_rdy_seen");
      check("t1_if_out", bus.IF_out, 32'h00A00093);
      bus.IF_req = 1'b0;
      tick();
      check("t1_pulse_one_cycle", bus.IF_rdy, 0);
      repeat (2) tick();

      // IF and MEM SAVE together: MEM first
      bus.IF_addr = 32'h104; bus.IF_req = 1'b1;
      bus.MEM_op = MEM_SAVE; bus.MEM_len = MEM_WORD;
      bus.MEM_addr = 32'h2000; bus.MEM_data = 32'hDEADBEEF;
      tick();
      check("t2_first_op", bus.ctl_op, MEM_SAVE);
      check("t2_first_addr", bus.ctl_addr, 32'h2000);
      check("t2_first_data", bus.ctl_data, 32'hDEADBEEF);
      wait_for(1, "t2_mem_rdy_seen");
      bus.MEM_op = MEM_NOP;
      wait_for(2, "t2_if_issue_seen");
      check("t2_if_addr", bus.ctl_addr, 32'h104);
      check("t2_if_op", bus.ctl_op, MEM_LOAD);
      wait_for(0, "t2_if_rdy_seen");
      check("t2_if_out", bus.IF_out, rd_f(32'h104));
      bus.IF_req = 1'b0;
      repeat (3) tick();

      // back-to-back MEM loads with IF waiting
      ack_dly = 0; done_dly = 1;
      b_g = n_grant;
      bus.IF_addr = 32'h300; bus.IF_req = 1'b1;
      bus.MEM_op = MEM_LOAD; bus.MEM_len = MEM_HALF; bus.MEM_addr = 32'h4000;
      for (int k = 0; k < 300 && (n_grant - b_g) < 6; k++) begin
         tick();
         if (bus.IF_rdy) bus.IF_req = 1'b0;
      end
      bus.MEM_op = MEM_NOP;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (bus.IF_rdy) bus.IF_req = 1'b0;
      end
      for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_STARVE_EN
         check($sformatf("t3_grant%0d_is_if", i + 1), 32'(g_is_if[b_g + i]), (i == 4) ? 1 : 0);
`else
         check($sformatf("t3_grant%0d_is_if", i + 1), 32'(g_is_if[b_g + i]), 0);
`endif
      end
`ifdef MEM_ARB_STARVE_EN
      check("t3_total_grants", n_grant - b_g, 6);
`else
      check("t3_total_grants", n_grant - b_g, 7);
      check("t3_if_served_last", 32'(g_is_if[b_g + 6]), 1);
`endif
      bus.IF_req = 1'b0;
      repeat (2) tick();

      // take_jmp while IF access is in WAIT
      ack_dly = 0; done_dly = 4;
      b_if = n_if_rdy; b_ack = n_ack;
      bus.IF_addr = 32'h500; bus.IF_req = 1'b1;
      wait_ack(b_ack, "t4_ack_seen");
      tick();
      bus.take_jmp = 1'b1; bus.IF_req = 1'b0;
      tick();
      bus.take_jmp = 1'b0;
      repeat (10) tick();
      check("t4_no_if_rdy", n_if_rdy - b_if, 0);
      check("t4_one_ack", n_ack - b_ack, 1);
      done_dly = 1;
      bus.IF_addr = 32'h600; bus.IF_req = 1'b1;
      wait_for(0, "t4_new_if_rdy");
      check("t4_new_if_out", bus.IF_out, rd_f(32'h600));
      check("t4_new_addr", rec_addr, 32'h600);
      bus.IF_req = 1'b0;
      repeat (2) tick();

      // take_jmp while IF request is still in ISSUE
      ack_dly = 3; done_dly = 1;
      b_ack = n_ack;
      bus.IF_addr = 32'h700; bus.IF_req = 1'b1;
      tick();
      check("t5_issue_valid", bus.ctl_valid, 1);
      bus.take_jmp = 1'b1; bus.IF_req = 1'b0;
      tick();
      check("t5_valid_dropped", bus.ctl_valid, 0);
      bus.take_jmp = 1'b0;
      repeat (6) tick();
      check("t5_nothing_acked", n_ack - b_ack, 0);

      // take_jmp during MEM SAVE: store completes
      ack_dly = 1; done_dly = 2;
      b_ack = n_ack; b_mem = n_mem_rdy;
      bus.MEM_op = MEM_SAVE; bus.MEM_len = MEM_BYTE;
      bus.MEM_addr = 32'h2100; bus.MEM_data = 32'h12345678;
      bus.take_jmp = 1'b1;
      wait_for(1, "t6_mem_rdy_seen");
      bus.MEM_op = MEM_NOP; bus.take_jmp = 1'b0;
      repeat (4) tick();
      check("t6_one_ack", n_ack - b_ack, 1);
      check("t6_one_mem_rdy", n_mem_rdy - b_mem, 1);
      check("t6_len", rec_len, MEM_BYTE);
      check("t6_data", rec_data, 32'h12345678);

      // rdy_in low holds the IF_rdy pulse
      ack_dly = 0; done_dly = 1;
      b_if = n_if_rdy;
      bus.IF_addr = 32'h900; bus.IF_req = 1'b1;
      wait_for(0, "t7_if_rdy_seen");
      rdy_in = 1'b0;
      tick();
      check("t7_freeze_hold", bus.IF_rdy, 1);
      tick();
      rdy_in = 1'b1; bus.IF_req = 1'b0;
      check("t7_reassert", bus.IF_rdy, 1);
      tick();
      check("t7_pulse_end", bus.IF_rdy, 0);
      check("t7_if_out", bus.IF_out, rd_f(32'h900));
      check("t7_one_pulse", n_if_rdy - b_if, 1);

      // reset while IF access is in WAIT
      ack_dly = 0; done_dly = 6;
      b_ack = n_ack;
      bus.IF_addr = 32'h800; bus.IF_req = 1'b1;
      wait_ack(b_ack, "t8_ack_seen");
      tick();
      tick();
      rst_in = 1'b1;
      #1;
      check("t8_async_valid", bus.ctl_valid, 0);
      check("t8_async_addr", bus.ctl_addr, 0);
      check("t8_async_if_out", bus.IF_out, 0);
      check("t8_async_mem_out", bus.MEM_out, 0);
      bus.IF_req = 1'b0;
      repeat (2) tick();
      rst_in = 1'b0;
      b_if = n_if_rdy; b_mem = n_mem_rdy;
      repeat (10) tick();
      check("t8_no_stale_if", n_if_rdy - b_if, 0);
      check("t8_no_stale_mem", n_mem_rdy - b_mem, 0);
      check("t8_idle_valid", bus.ctl_valid, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
